// File: rtl/aes128_pkg.sv
// AES-128 shared arithmetic, round constants and FSM encoding.
// Used by the iterative inverse cipher (optional AES128_INV_KEY_CACHE_EN).
package aes128_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t KEYFWD = 2'd1;
  localparam state_t ROUND  = 2'd2;
  localparam state_t DONE   = 2'd3;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b,
    input int         n
  );
    return (b << n) | (b >> (8 - n));
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    logic [7:0] y;
    y = gf_inv(b);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2)
             ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] b
  );
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3)
                ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] i
  );
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// One combinational AES inverse round.
// InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module aes128_inv_round
  import aes128_pkg::*;
(
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rk_i,
  input  logic             final_i,
  output logic [BLK_W-1:0] state_o
);

  logic [BLK_W-1:0] sr;
  logic [BLK_W-1:0] ak;
  logic [BLK_W-1:0] mc;

  function automatic logic [31:0] inv_mix(
    input logic [31:0] col
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = col;
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

  // row r rotates right by r, then each byte goes through inv S-box
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[BLK_W-1-8*(4*c+r) -: 8] = inv_sbox(
          state_i[BLK_W-1-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
  end

  // key add, then column mix unless this is the last round
  always_comb begin
    ak = sr ^ rk_i;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[BLK_W-1-32*c -: 32] = inv_mix(ak[BLK_W-1-32*c -: 32]);
    end
    state_o = final_i ? ak : mc;
  end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption: forward key pass, then 10 inverse rounds.
// Optional K10 cache under AES128_INV_KEY_CACHE_EN.
module aes128_inv_cipher_iter
  import aes128_pkg::*;
#(
  parameter int ZERO_OUT_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ct_in,
  input  logic [BLK_W-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] pt_out,
  output logic             busy
);

  state_t           fsm_q, fsm_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [3:0]       rcnt_p1;
  logic [BLK_W-1:0] st_q, st_d;
  logic [BLK_W-1:0] rk_q, rk_d;
  logic [BLK_W-1:0] res_q, res_d;
  logic [BLK_W-1:0] k_fwd;
  logic [BLK_W-1:0] k_prev;
  logic [BLK_W-1:0] rnd_out;

`ifdef AES128_INV_KEY_CACHE_EN
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] ck_key_q, ck_key_d;
  logic [BLK_W-1:0] ck_k10_q, ck_k10_d;
  logic             ck_vld_q, ck_vld_d;
  logic             hit;

  assign hit = ck_vld_q && (key_in == ck_key_q);
`endif

  function automatic logic [31:0] sub_rot(
    input logic [31:0] w
  );
    return {sbox(w[23:16]), sbox(w[15:8]),
            sbox(w[7:0]),   sbox(w[31:24])};
  endfunction

  function automatic logic [BLK_W-1:0] key_fwd(
    input logic [BLK_W-1:0] k,
    input logic [7:0]       rc
  );
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [BLK_W-1:0] key_inv(
    input logic [BLK_W-1:0] k,
    input logic [7:0]       rc
  );
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign rcnt_p1 = rcnt_q + 4'd1;
  assign k_fwd   = key_fwd(rk_q, rcon(rcnt_q));
  assign k_prev  = key_inv(rk_q, rcon(rcnt_p1));

  aes128_inv_round u_round (
    .state_i (st_q),
    .rk_i    (k_prev),
    .final_i (rcnt_q == 4'd0),
    .state_o (rnd_out)
  );

  // FSM, round counter and datapath next-state
  always_comb begin
    fsm_d  = fsm_q;
    rcnt_d = rcnt_q;
    st_d   = st_q;
    rk_d   = rk_q;
    res_d  = res_q;
`ifdef AES128_INV_KEY_CACHE_EN
    key_d    = key_q;
    ck_key_d = ck_key_q;
    ck_k10_d = ck_k10_q;
    ck_vld_d = ck_vld_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d   = ct_in;
          rk_d   = key_in;
          rcnt_d = 4'd1;
          fsm_d  = KEYFWD;
`ifdef AES128_INV_KEY_CACHE_EN
          key_d = key_in;
          if (hit) begin
            st_d   = ct_in ^ ck_k10_q;
            rk_d   = ck_k10_q;
            rcnt_d = 4'(NR - 1);
            fsm_d  = ROUND;
          end
`endif
        end
      end
      KEYFWD: begin
        rk_d   = k_fwd;
        rcnt_d = rcnt_p1;
        if (rcnt_q == 4'(NR)) begin
          st_d   = st_q ^ k_fwd;
          rcnt_d = 4'(NR - 1);
          fsm_d  = ROUND;
`ifdef AES128_INV_KEY_CACHE_EN
          ck_vld_d = 1'b1;
          ck_key_d = key_q;
          ck_k10_d = k_fwd;
`endif
        end
      end
      ROUND: begin
        st_d   = rnd_out;
        rk_d   = k_prev;
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd0) begin
          rcnt_d = 4'd0;
          res_d  = rnd_out;
          fsm_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // state registers, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      rcnt_q <= 4'd0;
      st_q   <= '0;
      rk_q   <= '0;
      res_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rcnt_q <= rcnt_d;
      st_q   <= st_d;
      rk_q   <= rk_d;
      res_q  <= res_d;
    end
  end

`ifdef AES128_INV_KEY_CACHE_EN
  // last key and its K10, valid only after a full key pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      ck_key_q <= '0;
      ck_k10_q <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      ck_key_q <= ck_key_d;
      ck_k10_q <= ck_k10_d;
      ck_vld_q <= ck_vld_d;
    end
  end
`endif

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = !in_ready;
  assign pt_out    = (ZERO_OUT_IDLE != 0 && !out_valid)
                   ? '0 : res_q;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Bench for aes128_inv_cipher_iter: known answers, random
// round trips through a forward AES model, corner sequences.
module tb_aes128_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct_in = '0;
  logic [127:0] key_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] pt_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes128_inv_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

`ifdef AES128_INV_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] sb[256];
  bit         cv = 1'b0;
  logic [127:0] ck = '0;

  task automatic chk(string nm, string what,
                     logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h want %h", nm, what, got, exp);
    end
  endtask

  task automatic chk1(string nm, string what, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %b want %b", nm, what, got, exp);
    end
  endtask

  task automatic chki(string nm, string what, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d want %0d", nm, what, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from the exp/log tables of generator 3 plus the affine map
  task automatic build_sbox();
    logic [7:0] ex[255];
    int         lg[256];
    logic [7:0] p;
    logic [7:0] inv;
    logic [7:0] o;
    logic [7:0] c;
    c = 8'h63;
    p = 8'h01;
    lg[0] = 0;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = o;
    end
  endtask

  function automatic logic [127:0] round_key(logic [127:0] key, int n);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  // forward cipher on a byte array; the DUT has to undo it
  function automatic logic [127:0] encrypt(logic [127:0] key,
                                           logic [127:0] pt);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] o;
    rk = round_key(key, 0);
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[4*c+q] = s[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      rk = round_key(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic run_op(string nm, logic [127:0] key, logic [127:0] ct,
                        logic [127:0] pt, bit poke, bit bp, bit early);
    int           lat;
    int           exp_lat;
    bit           hit;
    logic [127:0] k10;
    k10 = round_key(key, 10);
    hit = CACHE && cv && (key == ck);
    exp_lat = hit ? 10 : 20;
    @(negedge clk);
    chk1(nm, "in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    ct_in = ct;
    key_in = key;
    out_ready = early;
    @(negedge clk);
    in_valid = 1'b0;
    ct_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = {$urandom, $urandom, $urandom, $urandom};
    chk1(nm, "busy", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == exp_lat - 10) chk(nm, "k10", dut.rk_q, k10);
      in_valid = poke && (lat == 3 || lat == 15);
      ct_in = ~ct;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chki(nm, "latency", lat, exp_lat);
    chk(nm, "pt", pt_out, pt);
    if (bp) begin
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        chk(nm, "bp_pt", pt_out, pt);
        chk1(nm, "bp_valid", out_valid, 1'b1);
        chk1(nm, "bp_in_ready", in_ready, 1'b0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1(nm, "post_valid", out_valid, 1'b0);
    chk1(nm, "post_in_ready", in_ready, 1'b1);
    chk(nm, "post_pt", pt_out, 128'h0);
    out_ready = 1'b0;
    if (CACHE && !hit) begin
      cv = 1'b1;
      ck = key;
    end
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] p;
    build_sbox();

    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{C1_KEY, C1_CT, C1_PT};
    vecs[2] = '{B_KEY, B_CT, B_PT};
    for (int i = 3; i < 7; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      vecs[i] = '{k, encrypt(k, p), p};
    end
    vecs[7] = '{B_KEY, B_CT, B_PT};

    repeat (3) @(negedge clk);
    chk1("reset", "in_ready", in_ready, 1'b1);
    chk1("reset", "out_valid", out_valid, 1'b0);
    chk1("reset", "busy", busy, 1'b0);
    chk("reset", "pt", pt_out, 128'h0);
    rst_n = 1'b1;

    // abort in the middle of the inverse rounds
    @(negedge clk);
    in_valid = 1'b1;
    ct_in = C1_CT;
    key_in = C1_KEY;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst", "in_ready", in_ready, 1'b1);
    chk1("midrst", "out_valid", out_valid, 1'b0);
    chk1("midrst", "busy", busy, 1'b0);
    chk("midrst", "pt", pt_out, 128'h0);
    chk("midrst", "rk", dut.rk_q, 128'h0);
    cv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("c1_k10", C1_KEY, C1_CT, C1_PT, 1'b0, 1'b0, 1'b0);
    chk("c1_k10", "model_k10", round_key(C1_KEY, 10), C1_K10);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct,
             vecs[i].pt, 1'b0, 1'b0, i >= 3);

    run_op("backpressure", C1_KEY, C1_CT, C1_PT, 1'b0, 1'b1, 1'b0);
    run_op("busy_ignore", B_KEY, B_CT, B_PT, 1'b1, 1'b0, 1'b0);
    run_op("busy_ignore2", C1_KEY, C1_CT, C1_PT, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_inv_cipher_iter.md
Name: aes128_inv_cipher_iter

Overview:
Iterative AES-128 decryption core; the inverse-direction counterpart of the encryption round datapath. It accepts a 128-bit ciphertext and the cipher key over a valid/ready handshake. It derives the round-10 key with a forward key-schedule pass, then performs ten inverse rounds, one per clock, generating round keys backwards on the fly. It delivers the plaintext on a valid/ready output. All 128-bit buses use FIPS-197 byte order: bit [127:120] is byte 0, and the state is column-major.

Parameters:
ZERO_OUT_IDLE, 1, when 1 pt_out reads 0 whenever out_valid=0; when 0 pt_out holds the last result.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ct_in/key_in valid
in_ready  output  1  core can accept (IDLE only)
ct_in  input  128  ciphertext
key_in  input  128  cipher key (round key 0)
out_valid  output  1  pt_out valid
out_ready  input  1  consumer accepts pt_out
pt_out  output  128  plaintext
busy  output  1  high in KEYFWD, ROUND or DONE

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, pt_out=0.
  - Round counter=0 and all internal registers cleared.
  - Reset mid-operation aborts the operation with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch ct_in and key_in, set rk=key_in, rcnt=1, go to KEYFWD.
- KEYFWD (10 cycles, rcnt 1..10):
  - Each cycle, rk <= forward expansion of rk using Rcon[rcnt] (01,02,04,08,10,20,40,80,1b,36).
  - On the rcnt=10 edge: state_reg <= ct ^ K10, rk <= K10, rcnt <= 9, go to ROUND.
- ROUND (10 cycles, rcnt 9..0):
  - Compute rk_prev from rk with the inverse schedule using Rcon[rcnt+1]:
    - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0;
    - w0'=w0^SubWord(RotWord(w3'))^Rcon.
  - rcnt 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev).
  - rcnt 0: state <= InvSubBytes(InvShiftRows(state)) ^ rk_prev, with no InvMixColumns; go to DONE.
  - rk <= rk_prev each cycle.
- DONE:
  - out_valid=1, pt_out=state.
  - Stay until out_ready=1 at an edge, then go to IDLE.
  - pt_out and out_valid remain stable while out_ready=0.
- Latency: accept edge = E0; out_valid is first high after edge E20, i.e. 20 cycles.
- No back-to-back overlap: in_ready=0 from E0 until the DONE→IDLE edge.
- in_valid while busy is ignored. Inputs are not sampled except at the accept edge.
- out_ready is ignored when out_valid=0.
- Key-schedule arithmetic is bytewise XOR only. InvMixColumns uses GF(2^8) with polynomial 0x11b and coefficients 0e, 0b, 0d, 09.

Optional Feature:
AES128_INV_KEY_CACHE_EN
- Defined:
  - Hold the last key_in and its K10 in registers, with a cache_vld flag that is cleared on reset.
  - If key_in equals the cached key at accept, skip KEYFWD: state <= ct ^ K10 at the accept edge and go directly to ROUND.
  - Latency is then 10 cycles; a miss behaves as normal and refreshes the cache at the end of KEYFWD.
- Undefined: no cache registers; latency is always 20 cycles.

Decomposition:
- Package aes128_pkg holds:
  - sbox and inv_sbox functions;
  - xtime and gf_mul functions;
  - the rcon lookup (index 1..10);
  - the state enum {IDLE, KEYFWD, ROUND, DONE};
  - constants NR=10 and BLK_W=128.
- One sub-module, aes128_inv_round, is combinational:
  - inputs: state, round key, final flag;
  - output: next state;
  - it contains InvShiftRows, InvSubBytes, AddRoundKey and conditional InvMixColumns.
- The key schedule and FSM stay in the top.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff exactly 20 cycles after accept; internal K10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid → pt_out stable, in_ready=0; out_ready=1 → next cycle in_ready=1, out_valid=0, pt_out=0 (ZERO_OUT_IDLE=1).
- Busy ignore: assert in_valid with a different ct at cycles 3 and 15 → ignored; result still matches the C.1 pt.
- Reset mid-ROUND: rst_n=0 at cycle 14 → all outputs reset immediately; a new C.1 request then completes correctly.
- With AES128_INV_KEY_CACHE_EN: C.1 twice with the same key → second result 10 cycles after accept; a new key (B) → 20 cycles.
